// File: rtl/detector_paso_pkg.sv
// Shared parking package: passage FSM states, detector defaults and lot capacity.
package detector_paso_pkg;

  localparam int unsigned DEBOUNCE_CYCLES_DEF = 4;
  localparam int unsigned SYNC_STAGES_DEF     = 2;
  // Number of spaces in the lot, used by the space counter.
  localparam int unsigned CAPACIDAD           = 32;

  typedef enum logic [2:0] {
    IDLE,
    IN_A,
    IN_AB,
    IN_B,
    OUT_B,
    OUT_BA,
    OUT_A,
    WAIT_CLEAR
  } paso_state_e;

  // Debounced {a,b} pattern that keeps the FSM in a given state.
  function automatic logic [1:0] patron(input paso_state_e s);
    case (s)
      IN_A, OUT_A:   patron = 2'b10;
      IN_AB, OUT_BA: patron = 2'b11;
      IN_B, OUT_B:   patron = 2'b01;
      default:       patron = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/detector_paso_filtro_rebote.sv
// filtro_rebote: synchronizer followed by a debounce filter for one raw sensor.
// Ports: clk, reset (async, active-high), din (raw, async), dout (debounced level).
module filtro_rebote
  import detector_paso_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   deb_q, deb_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       cnt_inc;

  // Count cycles of disagreement; accept the new level once the count completes.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], din};
    deb_d   = deb_q;
    cnt_d   = '0;
    cnt_inc = cnt_q + CNT_W'(1);
    if (sync_q[SYNC_STAGES-1] != deb_q) begin
      if (cnt_inc == CNT_W'(DEBOUNCE_CYCLES)) begin
        deb_d = ~deb_q;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/detector_paso.sv
// detector_paso: two-beam gate passage detector producing entry/exit pulses.
// Ports: clk, reset (async, active-high), sensor_a (outer beam), sensor_b
// (inner beam); entrada/salida one-cycle pulses, busy outside IDLE, error
// one-cycle pulse on an illegal beam transition.
module detector_paso
  import detector_paso_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned SYNC_STAGES     = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic entrada,
  output logic salida,
  output logic busy,
  output logic error
);

  logic        deb_a, deb_b;
  logic [1:0]  pair;
  logic        bad;

  paso_state_e state_q, state_d;
  logic        entrada_q, entrada_d;
  logic        salida_q, salida_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;

  filtro_rebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_filtro_a (
    .clk  (clk),
    .reset(reset),
    .din  (sensor_a),
    .dout (deb_a)
  );

  filtro_rebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_filtro_b (
    .clk  (clk),
    .reset(reset),
    .din  (sensor_b),
    .dout (deb_b)
  );

  assign pair = {deb_a, deb_b};

  // Next state: forward step, back-out to previous pattern, abort, or illegal.
  always_comb begin
    state_d   = state_q;
    entrada_d = 1'b0;
    salida_d  = 1'b0;
    error_d   = 1'b0;
    bad       = 1'b0;
    if (state_q == WAIT_CLEAR) begin
      if (pair == 2'b00) state_d = IDLE;
    end else if (pair != patron(state_q)) begin
      case (state_q)
        IDLE: begin
          if (pair == 2'b10)      state_d = IN_A;
          else if (pair == 2'b01) state_d = OUT_B;
          else                    bad = 1'b1;
        end
        IN_A: begin
          if (pair == 2'b11)      state_d = IN_AB;
          else if (pair == 2'b00) state_d = IDLE;
          else                    bad = 1'b1;
        end
        IN_AB: begin
          if (pair == 2'b01)      state_d = IN_B;
          else if (pair == 2'b10) state_d = IN_A;
          else                    bad = 1'b1;
        end
        IN_B: begin
          if (pair == 2'b00) begin
            state_d   = IDLE;
            entrada_d = 1'b1;
          end else if (pair == 2'b11) state_d = IN_AB;
          else                        bad = 1'b1;
        end
        OUT_B: begin
          if (pair == 2'b11)      state_d = OUT_BA;
          else if (pair == 2'b00) state_d = IDLE;
          else                    bad = 1'b1;
        end
        OUT_BA: begin
          if (pair == 2'b10)      state_d = OUT_A;
          else if (pair == 2'b01) state_d = OUT_B;
          else                    bad = 1'b1;
        end
        OUT_A: begin
          if (pair == 2'b00) begin
            state_d  = IDLE;
            salida_d = 1'b1;
          end else if (pair == 2'b11) state_d = OUT_BA;
          else                        bad = 1'b1;
        end
        default: bad = 1'b1;
      endcase
      if (bad) begin
        state_d = WAIT_CLEAR;
        error_d = 1'b1;
      end
    end
    // Registered so busy tracks the state register exactly.
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      entrada_q <= 1'b0;
      salida_q  <= 1'b0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      entrada_q <= entrada_d;
      salida_q  <= salida_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
    end
  end

  assign entrada = entrada_q;
  assign salida  = salida_q;
  assign error   = error_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_detector_paso.sv
// Directed bench for detector_paso with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
module tb_detector_paso;

  logic clk = 1'b0;
  logic reset;
  logic sensor_a, sensor_b;
  logic entrada, salida, busy, error;

  int checks = 0;
  int errors = 0;

  // Pulse / busy counters accumulated by the monitor, cleared per segment.
  int n_ent = 0, n_sal = 0, n_err = 0, n_busy = 0;
  logic prev_pulse = 1'b0;

  typedef struct {
    logic        a;
    logic        b;
    int unsigned hold;
    int          ent;
    int          sal;
    int          err;
    logic        busy_end;
  } vec_t;

  vec_t tbl[$];

  detector_paso #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .reset   (reset),
    .sensor_a(sensor_a),
    .sensor_b(sensor_b),
    .entrada (entrada),
    .salida  (salida),
    .busy    (busy),
    .error   (error)
  );

  always #5 clk = ~clk;

  // Pulse counting and exclusivity / no-back-to-back checking.
  always @(negedge clk) begin
    if (reset) begin
      prev_pulse = 1'b0;
    end else begin
      if (entrada) n_ent++;
      if (salida)  n_sal++;
      if (error)   n_err++;
      if (busy)    n_busy++;
      if (entrada || salida || error) begin
        checks++;
        if ((int'(entrada) + int'(salida) + int'(error)) > 1 || prev_pulse) begin
          errors++;
          $display("FAIL pulse_excl t=%0t ent=%b sal=%b err=%b prev=%b required single isolated pulse",
                   $time, entrada, salida, error, prev_pulse);
        end
      end
      prev_pulse = entrada || salida || error;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clr();
    n_ent = 0; n_sal = 0; n_err = 0; n_busy = 0;
  endtask

  task automatic apply(input logic a, input logic b, input int unsigned n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;

    // Entry
    tbl.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 10, 0, 0, 0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 10, 0, 0, 0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 10, 1, 0, 0, 1'b0});
    // Exit
    tbl.push_back('{1'b0, 1'b1, 10, 0, 0, 0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 10, 0, 0, 0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 10, 0, 1, 0, 1'b0});
    // Car backs out, then aborts from IN_A
    tbl.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 10, 0, 0, 0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 10, 0, 0, 0, 1'b0});
    // Both beams blocked together; WAIT_CLEAR holds until 00
    tbl.push_back('{1'b1, 1'b1, 10, 0, 0, 1, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 10, 0, 0, 0, 1'b0});
    // IN_A -01-> illegal
    tbl.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 10, 0, 0, 1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 10, 0, 0, 0, 1'b0});
    // IN_B -10-> illegal
    tbl.push_back('{1'b1, 1'b0, 10, 0, 0, 0, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 10, 0, 0, 0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 10, 0, 0, 0, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 10, 0, 0, 1, 1'b1});
    tbl.push_back('{1'b0, 1'b0, 10, 0, 0, 0, 1'b0});

    // Outputs while reset is held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_entrada", int'(entrada), 0);
    chk("rst_salida",  int'(salida),  0);
    chk("rst_busy",    int'(busy),    0);
    chk("rst_error",   int'(error),   0);
    reset = 1'b0;
    apply(1'b0, 1'b0, 5);
    chk("idle_busy", int'(busy), 0);

    // Table-driven segments
    foreach (tbl[i]) begin
      clr();
      apply(tbl[i].a, tbl[i].b, tbl[i].hold);
      chk($sformatf("seg%0d_entrada", i), n_ent, tbl[i].ent);
      chk($sformatf("seg%0d_salida", i),  n_sal, tbl[i].sal);
      chk($sformatf("seg%0d_error", i),   n_err, tbl[i].err);
      chk($sformatf("seg%0d_busy", i),    int'(busy), int'(tbl[i].busy_end));
    end

    // Entry latency: pulse exactly 7 edges after the final 00 is first sampled
    apply(1'b1, 1'b0, 10);
    apply(1'b1, 1'b1, 10);
    apply(1'b0, 1'b1, 10);
    clr();
    apply(1'b0, 1'b0, 6);
    chk("lat_before", int'(entrada), 0);
    apply(1'b0, 1'b0, 1);
    chk("lat_at7", int'(entrada), 1);
    apply(1'b0, 1'b0, 1);
    chk("lat_after", int'(entrada), 0);
    apply(1'b0, 1'b0, 5);
    chk("lat_count", n_ent, 1);
    chk("lat_busy", int'(busy), 0);

    // 3-cycle glitch: rejected, busy never rises
    clr();
    apply(1'b1, 1'b0, 3);
    apply(1'b0, 1'b0, 12);
    chk("glitch3_busy_cycles", n_busy, 0);
    chk("glitch3_pulses", n_ent + n_sal + n_err, 0);

    // 4-cycle pulse: accepted into IN_A for 4 cycles, then aborts silently
    clr();
    apply(1'b1, 1'b0, 4);
    apply(1'b0, 1'b0, 12);
    chk("glitch4_busy_cycles", n_busy, 4);
    chk("glitch4_pulses", n_ent + n_sal + n_err, 0);

    // Reset mid-passage in IN_AB, then 01,00: no entrada
    apply(1'b1, 1'b0, 10);
    apply(1'b1, 1'b1, 10);
    chk("midrst_pre_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    chk("midrst_async_busy", int'(busy), 0);
    sensor_a = 1'b0;
    sensor_b = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_outs", int'({entrada, salida, busy, error}), 0);
    clr();
    reset = 1'b0;
    apply(1'b0, 1'b1, 10);
    chk("midrst_blocked_busy", int'(busy), 1);
    apply(1'b0, 1'b0, 10);
    chk("midrst_entrada", n_ent, 0);
    chk("midrst_salida",  n_sal, 0);
    chk("midrst_error",   n_err, 0);
    chk("midrst_busy_end", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/detector_paso.md
DETECTOR_PASO -- requirements
Module: detector_paso

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive stable synchronized samples required to accept a sensor level change (legal range 1..255).
REQ-002 Parameter SYNC_STAGES, default 2, is the synchronizer depth per sensor input (legal range 2..3).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 sensor_a  input  1  raw outer gate beam (1 = beam blocked), asynchronous to clk.
REQ-006 sensor_b  input  1  raw inner gate beam (1 = beam blocked), asynchronous to clk.
REQ-007 entrada  output  1  one-cycle pulse per completed vehicle entry; drives the space counter increment input.
REQ-008 salida  output  1  one-cycle pulse per completed vehicle exit; drives the space counter decrement input.
REQ-009 busy  output  1  high whenever the FSM is outside IDLE.
REQ-010 error  output  1  one-cycle pulse on an illegal sensor transition.

Function
REQ-011 Each sensor passes through a SYNC_STAGES flip-flop synchronizer, then a debounce filter producing deb_a / deb_b.
REQ-012 Debounce: a per-sensor counter increments while the synchronized value differs from the debounced value, clears when they match, and the debounced value toggles (counter clears) when the count reaches DEBOUNCE_CYCLES.
REQ-013 FSM states: IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, WAIT_CLEAR; the FSM evaluates the pair (deb_a, deb_b) every cycle.
REQ-014 Entry path: IDLE -10-> IN_A -11-> IN_AB -01-> IN_B -00-> IDLE with entrada = 1 for exactly one cycle.
REQ-015 Exit path: IDLE -01-> OUT_B -11-> OUT_BA -10-> OUT_A -00-> IDLE with salida = 1 for exactly one cycle.
REQ-016 Backing out: a pair value equal to the previous state's pattern returns to that previous state (e.g. IN_AB -10-> IN_A), with no pulse.
REQ-017 Abort: from IN_A or OUT_B, pair 00 returns to IDLE with no pulse.
REQ-018 Any other pair change (e.g. IDLE -11->, IN_A -01->, IN_B -10->) is illegal: error pulses for one cycle and the FSM enters WAIT_CLEAR.
REQ-019 WAIT_CLEAR exits to IDLE only when the pair is 00, with no pulse.
REQ-020 An unchanged pair holds the current state indefinitely; there is no timeout.
REQ-021 entrada, salida and error are registered outputs, mutually exclusive, and never high for two consecutive cycles.
REQ-022 Latency: the output pulse appears SYNC_STAGES + DEBOUNCE_CYCLES + 1 rising edges after the final raw transition to 00 is first sampled.
REQ-023 Glitches shorter than DEBOUNCE_CYCLES cycles after synchronization produce no state change.

Reset
REQ-024 While reset is high: state = IDLE; synchronizer flops, debounced values and debounce counters = 0; entrada = salida = error = busy = 0.
REQ-025 Reset asserted mid-sequence discards the partial passage; no pulse is generated on release.
REQ-026 After reset release with a sensor held blocked, the level is accepted through the normal debounce path and the FSM follows REQ-014..REQ-019.

Structure
REQ-027 The state enumeration and the DEBOUNCE_CYCLES / SYNC_STAGES defaults reside in the shared parking package, alongside the capacity constant used by the space counter.
REQ-028 A sub-module filtro_rebote (synchronizer plus debounce, 1-bit in, 1-bit out) is instantiated once per sensor.
REQ-029 The debounce counter width is $clog2(DEBOUNCE_CYCLES+1) bits.

Verification (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-030 Raw AB sequence 00,10,11,01,00, each held 10 cycles -> exactly one entrada pulse, 7 edges after the final 00; salida = error = 0.
REQ-031 Raw sequence 00,01,11,10,00, each held 10 cycles -> exactly one salida pulse; entrada = 0.
REQ-032 sensor_a high for 3 cycles, otherwise idle -> no state change, busy stays 0.
REQ-033 Sequence 00,10,11,10,00 (car backs out) -> no pulse; FSM ends in IDLE.
REQ-034 Both sensors rising in the same cycle -> error pulse for one cycle, busy = 1 until both are cleared, then IDLE with no entrada or salida.
REQ-035 Reset asserted while in IN_AB, then 01,00 applied -> no entrada; all outputs 0 during reset.
